// File: rtl/add_serial_pkg.sv
// Shared types and defaults for the serial-adder scheduler: state encoding and
// the adder width and cycle count it is built around.
package add_serial_pkg;

  localparam int W_DEF          = 8;
  localparam int ADD_CYCLES_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPT,
    S_RESP
  } sched_state_t;

  // The counter must hold 0..n-1; n=1 still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr, wrapping modulo
// NREQ. It returns a one-hot grant and the matching index, or nothing when en is low.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler that shares one serial adder among NREQ requesters.
// Optional self-check: define ADD_SERIAL_SCHED_CHECK_EN to add the shadow sum and the chk_err port.
module add_serial_sched
  import add_serial_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int W          = W_DEF,
  parameter int ADD_CYCLES = ADD_CYCLES_DEF,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              add_en,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_clr,
  input  logic [W-1:0]      add_out,
`ifdef ADD_SERIAL_SCHED_CHECK_EN
  output logic              chk_err,
`endif
  output logic              busy
);

  localparam int                CNT_W    = cnt_width(ADD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ADD_CYCLES - 1);
  localparam logic [IDW-1:0]    ID_LAST  = IDW'(NREQ - 1);

  sched_state_t     state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     add_a_q, add_a_d, add_b_q, add_b_d;
  logic [W-1:0]     rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             arb_en;

  assign arb_en = (state_q == S_IDLE);

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    rsp_sum_d = rsp_sum_q;
    rsp_id_d  = rsp_id_q;
    case (state_q)
      S_IDLE: if (|gnt) begin
        add_a_d  = req_a[int'(gnt_id)*W +: W];
        add_b_d  = req_b[int'(gnt_id)*W +: W];
        rsp_id_d = gnt_id;
        rr_ptr_d = (gnt_id == ID_LAST) ? '0 : gnt_id + IDW'(1);
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_CAPT;
      end
      S_CAPT: begin
        rsp_sum_d = add_out;
        state_d   = S_RESP;
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      rsp_sum_q <= '0;
      rsp_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  // Clearing in S_CAPT parks the adder in IDLE while the response waits.
  assign req_ready = gnt;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign add_en    = (state_q == S_LOAD);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_clr   = rst | (state_q == S_CAPT);
  assign busy      = (state_q != S_IDLE);

`ifdef ADD_SERIAL_SCHED_CHECK_EN
  logic [W-1:0] shadow_q;
  logic         chk_err_q;

  function automatic logic [W-1:0] sum_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (state_q == S_LOAD) shadow_q <= sum_mod(add_a_q, add_b_q);
      if (state_q == S_CAPT && add_out != shadow_q) chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule
